at24c02_test_sequencer: RTL
===========================

// Module: at24c02_test_sequencer
// PURPOSE
//  Command sequencer directly upstream of the I2C byte engine. On a start pulse it writes a
//  known byte pattern into an AT24C02 EEPROM, waits the EEPROM write-cycle time after each
//  byte, reads every byte back and compares it. It reports pass/fail, a mismatch count and
//  the byte read from the first location for the on-board debug/LED path.
// PARAMETERS
//  DEV_ADDR      7'h50   7-bit I2C slave address placed on cmd_dev_addr
//  BASE_ADDR     8'h00   first EEPROM word address under test
//  NUM_BYTES     8       bytes written then read (1..256)
//  DATA_SEED     8'hA5   pattern byte i = DATA_SEED + i (mod 256)
//  WR_DELAY_CYC  60000   sys_clk cycles waited after each write ACK/NACK (5 ms at 12 MHz)
//  MAX_RETRY     3       re-issues allowed per byte on NACK before FAIL
// PORTS
//  sys_clk        in   1   sole clock; all logic on rising edge
//  rst            in   1   synchronous, active-high reset
//  start          in   1   1-cycle pulse; accepted only in IDLE, DONE or FAIL
//  cmd_valid      out  1   command present on cmd_* fields
//  cmd_ready      in   1   engine accepts command when cmd_valid && cmd_ready
//  cmd_rw         out  1   0 = write byte, 1 = random read byte
//  cmd_dev_addr   out  7   = DEV_ADDR
//  cmd_reg_addr   out  8   EEPROM word address
//  cmd_wr_data    out  8   write byte (0 when cmd_rw=1)
//  rsp_valid      in   1   1-cycle pulse: engine finished current command
//  rsp_nack       in   1   qualified by rsp_valid: any NACK during the transfer
//  rsp_rd_data    in   8   qualified by rsp_valid when cmd_rw=1
//  busy           out  1   high in every state except IDLE/DONE/FAIL
//  pass           out  1   high in DONE with mismatch_cnt==0
//  fail           out  1   high in FAIL, or in DONE with mismatch_cnt!=0
//  mismatch_cnt   out  9   read-back bytes differing from expected (saturates at 511)
//  first_rd_data  out  8   byte read from BASE_ADDR in the latest run
// BEHAVIOUR
//  - Reset: state IDLE, every output 0, index/retry/delay counters 0. Reset overrides all,
//    including mid-transfer; cmd_valid drops the next edge, late rsp_valid is ignored.
//  - States: IDLE, WR_REQ, WR_WAIT, WR_DLY, RD_REQ, RD_WAIT, DONE, FAIL.
//  - start in IDLE/DONE/FAIL -> WR_REQ; clears idx, retry, mismatch_cnt, first_rd_data,
//    pass, fail. start in any busy state is ignored.
//  - WR_REQ: cmd_valid=1, cmd_rw=0, addr=BASE_ADDR+idx (8-bit wrap), data=DATA_SEED+idx.
//    Fields stable while cmd_valid && !cmd_ready. Handshake edge -> WR_WAIT, cmd_valid=0.
//  - WR_WAIT: on rsp_valid -> WR_DLY, delay counter loaded with WR_DELAY_CYC-1.
//    Record NACK flag. Stay in WR_WAIT indefinitely otherwise (no timeout).
//  - WR_DLY: counts to 0, then: NACK recorded and retry<MAX_RETRY -> retry++, WR_REQ same idx;
//    NACK and retry==MAX_RETRY -> FAIL; ACK -> retry=0, idx++, WR_REQ, or RD_REQ with idx=0
//    when idx was NUM_BYTES-1. Delay is applied after NACKs too (EEPROM busy NACKs).
//  - RD_REQ: as WR_REQ with cmd_rw=1, cmd_wr_data=0. Handshake -> RD_WAIT.
//  - RD_WAIT on rsp_valid: NACK -> same retry rule (no delay; straight back to RD_REQ or FAIL).
//    ACK -> compare rsp_rd_data with DATA_SEED+idx; mismatch increments mismatch_cnt
//    (saturating); idx==0 loads first_rd_data; last idx -> DONE else idx++, RD_REQ.
//  - pass/fail registered, updated on the edge entering DONE/FAIL; held until next start/rst.
//  - rsp_valid outside WR_WAIT/RD_WAIT ignored. cmd_valid and rsp_valid same cycle impossible
//    by engine contract; not checked.
//  - Counters: idx 8 bits (NUM_BYTES=256 wraps cleanly), delay counter $clog2(WR_DELAY_CYC)+1.
// TESTING (bench uses WR_DELAY_CYC=20, NUM_BYTES=4 unless stated; engine model w/ EEPROM array)
//  1 All ACK, good memory: start -> writes A5,A6,A7,A8 to 00..03, each >=20 cycles apart,
//    4 reads -> pass=1, fail=0, mismatch_cnt=0, first_rd_data=8'hA5, busy=0.
//  2 Engine holds cmd_ready low 7 cycles -> cmd_* stable and cmd_valid held; one command each.
//  3 Byte 2 write NACKs twice then ACKs -> 3 writes to addr 02, pass=1; NACK 4 times -> FAIL,
//    fail=1, no read commands issued.
//  4 Memory model corrupts addr 01 to 8'h00 -> DONE, mismatch_cnt=1, fail=1, pass=0.
//  5 BASE_ADDR=8'hFE -> addresses FE,FF,00,01 in order (wrap), first_rd_data from FE.
//  6 rst asserted in WR_DLY and in RD_WAIT -> next edge: IDLE, all outputs 0; start ignored
//    while busy; start in DONE reruns and clears prior results.

Source files
------------

// File: rtl/at24c02_test_sequencer.sv
// AT24C02 write/read-back test sequencer sitting in front of the I2C byte engine.
// Writes DATA_SEED+i to NUM_BYTES consecutive word addresses, then reads each back and compares.
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_IDLE   | out of reset, waiting for start
// S_WR_REQ | write command presented, waiting for cmd_ready
// S_WR_WAIT| write command accepted, waiting for engine response
// S_WR_DLY | EEPROM internal write cycle (after ACK or busy NACK)
// S_RD_REQ | random-read command presented, waiting for cmd_ready
// S_RD_WAIT| read command accepted, waiting for engine response
// S_DONE   | all bytes read back; pass/fail reflect the compare
// S_FAIL   | retry budget exhausted on a NACK

module at24c02_test_sequencer #(
    parameter logic [6:0] DEV_ADDR     = 7'h50,
    parameter logic [7:0] BASE_ADDR    = 8'h00,
    parameter int         NUM_BYTES    = 8,
    parameter logic [7:0] DATA_SEED    = 8'hA5,
    parameter int         WR_DELAY_CYC = 60000,
    parameter int         MAX_RETRY    = 3
) (
    input  logic       i_sys_clk,
    input  logic       i_rst,
    input  logic       i_start,
    output logic       o_cmd_valid,
    input  logic       i_cmd_ready,
    output logic       o_cmd_rw,
    output logic [6:0] o_cmd_dev_addr,
    output logic [7:0] o_cmd_reg_addr,
    output logic [7:0] o_cmd_wr_data,
    input  logic       i_rsp_valid,
    input  logic       i_rsp_nack,
    input  logic [7:0] i_rsp_rd_data,
    output logic       o_busy,
    output logic       o_pass,
    output logic       o_fail,
    output logic [8:0] o_mismatch_cnt,
    output logic [7:0] o_first_rd_data
);

    localparam int DLY_W = $clog2(WR_DELAY_CYC) + 1;
    localparam int RTY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [DLY_W-1:0] DLY_LOAD = DLY_W'(WR_DELAY_CYC - 1);
    localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);
    localparam logic [7:0]       LAST_IDX = 8'(NUM_BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_REQ,
        S_WR_WAIT,
        S_WR_DLY,
        S_RD_REQ,
        S_RD_WAIT,
        S_DONE,
        S_FAIL
    } state_t;

    state_t           r_state, w_state;
    logic [7:0]       r_idx, w_idx;
    logic [RTY_W-1:0] r_retry, w_retry;
    logic [DLY_W-1:0] r_dly, w_dly;
    logic             r_nack, w_nack;
    logic [8:0]       r_mm, w_mm;
    logic [7:0]       r_first, w_first;
    logic             r_pass, w_pass;
    logic             r_fail, w_fail;

    logic [7:0]       w_pattern;
    logic             w_req;

    assign w_pattern = DATA_SEED + r_idx;
    assign w_req     = (r_state == S_WR_REQ) || (r_state == S_RD_REQ);

    always_ff @(posedge i_sys_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_retry <= '0;
            r_dly   <= '0;
            r_nack  <= 1'b0;
            r_mm    <= '0;
            r_first <= '0;
            r_pass  <= 1'b0;
            r_fail  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_idx   <= w_idx;
            r_retry <= w_retry;
            r_dly   <= w_dly;
            r_nack  <= w_nack;
            r_mm    <= w_mm;
            r_first <= w_first;
            r_pass  <= w_pass;
            r_fail  <= w_fail;
        end
    end

    always_comb begin
        w_state = r_state;
        w_idx   = r_idx;
        w_retry = r_retry;
        w_dly   = r_dly;
        w_nack  = r_nack;
        w_mm    = r_mm;
        w_first = r_first;
        w_pass  = r_pass;
        w_fail  = r_fail;
        case (r_state)
            S_IDLE, S_DONE, S_FAIL: begin
                if (i_start) begin
                    w_state = S_WR_REQ;
                    w_idx   = '0;
                    w_retry = '0;
                    w_mm    = '0;
                    w_first = '0;
                    w_pass  = 1'b0;
                    w_fail  = 1'b0;
                end
            end
            S_WR_REQ: begin
                if (i_cmd_ready) w_state = S_WR_WAIT;
            end
            S_WR_WAIT: begin
                if (i_rsp_valid) begin
                    w_state = S_WR_DLY;
                    w_dly   = DLY_LOAD;
                    w_nack  = i_rsp_nack;
                end
            end
            S_WR_DLY: begin
                // The wait applies after a NACK too: the EEPROM NACKs while its write cycle runs.
                if (r_dly != '0) begin
                    w_dly = r_dly - 1'b1;
                end else if (r_nack) begin
                    if (r_retry < RTY_MAX) begin
                        w_retry = r_retry + 1'b1;
                        w_state = S_WR_REQ;
                    end else begin
                        w_state = S_FAIL;
                        w_pass  = 1'b0;
                        w_fail  = 1'b1;
                    end
                end else begin
                    w_retry = '0;
                    if (r_idx == LAST_IDX) begin
                        w_idx   = '0;
                        w_state = S_RD_REQ;
                    end else begin
                        w_idx   = r_idx + 8'd1;
                        w_state = S_WR_REQ;
                    end
                end
            end
            S_RD_REQ: begin
                if (i_cmd_ready) w_state = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (i_rsp_valid) begin
                    if (i_rsp_nack) begin
                        if (r_retry < RTY_MAX) begin
                            w_retry = r_retry + 1'b1;
                            w_state = S_RD_REQ;
                        end else begin
                            w_state = S_FAIL;
                            w_pass  = 1'b0;
                            w_fail  = 1'b1;
                        end
                    end else begin
                        w_retry = '0;
                        if ((i_rsp_rd_data != w_pattern) && (r_mm != 9'h1FF)) w_mm = r_mm + 9'd1;
                        if (r_idx == 8'd0) w_first = i_rsp_rd_data;
                        if (r_idx == LAST_IDX) begin
                            w_state = S_DONE;
                            w_pass  = (w_mm == 9'd0);
                            w_fail  = (w_mm != 9'd0);
                        end else begin
                            w_idx   = r_idx + 8'd1;
                            w_state = S_RD_REQ;
                        end
                    end
                end
            end
            default: w_state = S_IDLE;
        endcase
    end

    // Command fields are forced to zero outside the request states so reset leaves every output at 0.
    assign o_cmd_valid     = w_req;
    assign o_cmd_rw        = (r_state == S_RD_REQ);
    assign o_cmd_dev_addr  = w_req ? DEV_ADDR : 7'd0;
    assign o_cmd_reg_addr  = w_req ? (BASE_ADDR + r_idx) : 8'd0;
    assign o_cmd_wr_data   = (r_state == S_WR_REQ) ? w_pattern : 8'd0;
    assign o_busy          = !((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_FAIL));
    assign o_pass          = r_pass;
    assign o_fail          = r_fail;
    assign o_mismatch_cnt  = r_mm;
    assign o_first_rd_data = r_first;

endmodule
